// File: rtl/impulse_detector.sv
// Impulse detector: tracks |sample| against a threshold, reports the peak and rise
// length of each impulse with a one-cycle trigger, then ignores input for a refractory window.
module impulse_detector #(
    parameter int HOLD_PWR   = 8,
    parameter int ATTACK_PWR = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  in_valid,
    input  logic [26:0]           in_sample,
    input  logic [25:0]           threshold,
    output logic                  trig,
    output logic [25:0]           peak,
    output logic [ATTACK_PWR-1:0] attack_len,
    output logic                  busy,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ATTACK = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // The rise is forced to end on the sample that brings len to its maximum.
    localparam logic [ATTACK_PWR-1:0] LEN_FORCE = {{(ATTACK_PWR-1){1'b1}}, 1'b0};
    localparam logic [HOLD_PWR-1:0]   HCNT_LAST = '1;

    // Stage 1: saturating magnitude
    logic [26:0] neg_sample;
    logic [25:0] abs_sample;
    logic [25:0] mag_r;
    logic        mag_valid;

    assign neg_sample = -in_sample;

    always_comb begin
        abs_sample = in_sample[25:0];
        if (in_sample[26]) begin
            // Only -2^26 negates to a value with bit 26 set.
            abs_sample = neg_sample[26] ? '1 : neg_sample[25:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mag_r     <= '0;
            mag_valid <= 1'b0;
        end else begin
            mag_valid <= in_valid;
            if (in_valid) begin
                mag_r <= abs_sample;
            end
        end
    end

    // Stage 2: detection FSM
    state_t                state, state_next;
    logic [25:0]           pk, pk_next;
    logic [ATTACK_PWR-1:0] len, len_next;
    logic [HOLD_PWR-1:0]   hcnt, hcnt_next;
    logic                  trig_next;
    logic [25:0]           peak_next;
    logic [ATTACK_PWR-1:0] attack_len_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pk         <= '0;
            len        <= '0;
            hcnt       <= '0;
            trig       <= 1'b0;
            peak       <= '0;
            attack_len <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            pk         <= pk_next;
            len        <= len_next;
            hcnt       <= hcnt_next;
            trig       <= trig_next;
            peak       <= peak_next;
            attack_len <= attack_len_next;
            busy       <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next      = state;
        pk_next         = pk;
        len_next        = len;
        hcnt_next       = hcnt;
        trig_next       = 1'b0;
        peak_next       = peak;
        attack_len_next = attack_len;

        if (!enable) begin
            state_next = IDLE;
            pk_next    = '0;
            len_next   = '0;
            hcnt_next  = '0;
        end else if (mag_valid) begin
            case (state)
                IDLE: begin
                    if (mag_r > threshold) begin
                        state_next = ATTACK;
                        pk_next    = mag_r;
                        len_next   = {{(ATTACK_PWR-1){1'b0}}, 1'b1};
                    end
                end
                ATTACK: begin
                    if (mag_r >= pk) begin
                        pk_next  = mag_r;
                        len_next = len + 1'b1;
                        if (len == LEN_FORCE) begin
                            trig_next       = 1'b1;
                            peak_next       = mag_r;
                            attack_len_next = len + 1'b1;
                            state_next      = HOLD;
                            hcnt_next       = '0;
                        end
                    end else begin
                        trig_next       = 1'b1;
                        peak_next       = pk;
                        attack_len_next = len;
                        state_next      = HOLD;
                        hcnt_next       = '0;
                    end
                end
                HOLD: begin
                    hcnt_next = hcnt + 1'b1;
                    if (hcnt == HCNT_LAST) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_impulse_detector.sv
// Bench for impulse_detector: an array-scanning reference model fills an expected
// trigger queue; a monitor pops and compares on every trig pulse.
module tb_impulse_detector;
  localparam int AP       = 8;
  localparam int HOLD_LEN = 256;
  localparam int MAX_LEN  = 255;
  localparam int W        = 16 + 26 + AP;

  // clock / reset
  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          in_valid;
  logic [26:0]   in_sample;
  logic [25:0]   threshold;
  logic          trig;
  logic [25:0]   peak;
  logic [AP-1:0] attack_len;
  logic          busy;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  impulse_detector #(.HOLD_PWR(8), .ATTACK_PWR(AP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
    .in_sample(in_sample), .threshold(threshold), .trig(trig), .peak(peak),
    .attack_len(attack_len), .busy(busy), .state_dbg(state_dbg)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [W-1:0]        exp_q[$];
  logic signed [26:0]  stim[$];
  logic [25:0]         mags[$];
  bit                  exp_busy[$];
  int                  cap_cycle[1024];
  int                  n_checks = 0;
  int                  n_fail = 0;
  logic [25:0]         last_peak = '0;
  logic [AP-1:0]       last_len = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [25:0] ref_mag(input logic signed [26:0] s);
    longint v;
    v = longint'(s);
    if (v < 0) v = -v;
    if (v > 64'd67108863) v = 67108863;
    return v[25:0];
  endfunction

  // Reference model: scan the whole sample list, locating each impulse as a
  // crossing followed by a non-decreasing run, then skip the refractory samples.
  task automatic build_model(input logic [25:0] thr);
    int n, i, e, len, hi;
    logic [25:0] pk;
    bit ended;
    n = stim.size();
    mags.delete();
    exp_busy.delete();
    for (int k = 0; k < n; k++) begin
      mags.push_back(ref_mag(stim[k]));
      exp_busy.push_back(1'b0);
    end
    i = 0;
    while (i < n) begin
      if (mags[i] > thr) begin
        pk = mags[i];
        len = 1;
        ended = 1'b0;
        e = n - 1;
        for (int j = i + 1; j < n && !ended; j++) begin
          if (mags[j] >= pk) begin
            pk = mags[j];
            len++;
            if (len == MAX_LEN) begin
              ended = 1'b1;
              e = j;
            end
          end else begin
            ended = 1'b1;
            e = j;
          end
        end
        if (ended) begin
          exp_q.push_back({16'(e), pk, AP'(len)});
          last_peak = pk;
          last_len = AP'(len);
          hi = (e + HOLD_LEN - 1 < n - 1) ? e + HOLD_LEN - 1 : n - 1;
          for (int k = i; k <= hi; k++) exp_busy[k] = 1'b1;
          i = e + HOLD_LEN + 1;
        end else begin
          for (int k = i; k < n; k++) exp_busy[k] = 1'b1;
          i = n;
        end
      end else begin
        i++;
      end
    end
  endtask

  // driver tasks
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic drive(input logic signed [26:0] s, input int idx);
    in_sample = s;
    in_valid = 1'b1;
    if (idx >= 0) cap_cycle[idx] = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_stim(input int gap_max);
    int n;
    n = stim.size();
    build_model(threshold);
    for (int k = 0; k < n; k++) begin
      drive(stim[k], k);
      check("busy", busy, (k == 0) ? 1'b0 : exp_busy[k-1]);
      idle($urandom_range(0, gap_max));
    end
    idle(2);
    check("busy_end", busy, exp_busy[n-1]);
  endtask

  task automatic flush();
    idle(3);
    check("drain", exp_q.size(), 0);
    enable = 1'b0;
    @(negedge clk);
    check("flush_busy", busy, 0);
    enable = 1'b1;
  endtask

  // monitor
  logic trig_prev = 1'b0;
  always @(negedge clk) begin
    logic [W-1:0] item;
    if (reset && trig) begin
      check("trig_single", trig_prev, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_trig", 1, 0);
      end else begin
        item = exp_q.pop_front();
        check("peak", peak, item[AP+25:AP]);
        check("attack_len", attack_len, item[AP-1:0]);
        check("trig_latency", cyc, cap_cycle[item[W-1:W-16]] + 1);
      end
    end
    trig_prev = trig;
  end

  // stimulus
  initial begin
    int lvl, burst;
    logic signed [26:0] v;
    reset = 1'b0;
    enable = 1'b0;
    in_valid = 1'b0;
    in_sample = '0;
    threshold = '0;
    idle(3);
    check("rst_trig", trig, 0);
    check("rst_peak", peak, 0);
    check("rst_len", attack_len, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, 0);
    reset = 1'b1;
    enable = 1'b1;
    idle(2);

    // T1: basic impulse
    threshold = 26'd1000;
    stim = '{27'sd0, 27'sd500, 27'sd2000, 27'sd3000, 27'sd2500};
    run_stim(0);
    flush();

    // T2: saturated most-negative sample
    threshold = 26'd0;
    stim = '{27'sh4000000, 27'sd0};
    run_stim(0);
    flush();

    // T3: refractory window
    threshold = 26'd1000;
    stim.delete();
    for (int k = 0; k < 400; k++) begin
      v = 27'($urandom_range(0, 800));
      if ($urandom_range(0, 1) == 1) v = -v;
      stim.push_back(v);
    end
    stim[0] = 27'sd5000;
    stim[100] = -27'sd5000;
    stim[300] = 27'sd5000;
    run_stim(1);
    flush();

    // T4: async reset mid-attack
    threshold = 26'd1000;
    drive(27'sd2000, -1);
    drive(27'sd3000, -1);
    idle(1);
    check("t4_armed", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("t4_trig", trig, 0);
    check("t4_peak", peak, 0);
    check("t4_len", attack_len, 0);
    check("t4_busy", busy, 0);
    last_peak = '0;
    last_len = '0;
    @(negedge clk);
    reset = 1'b1;
    idle(1);
    stim = '{27'sd100, 27'sd4000, 27'sd5000, -27'sd5000, 27'sd4500, 27'sd10};
    run_stim(2);
    flush();

    // T5: enable low mid-attack, then equal-to-threshold input
    threshold = 26'd1000;
    drive(27'sd2000, -1);
    drive(27'sd3000, -1);
    idle(1);
    enable = 1'b0;
    @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_state", state_dbg, 0);
    check("t5_peak", peak, last_peak);
    check("t5_len", attack_len, last_len);
    enable = 1'b1;
    stim = '{27'sd1000, -27'sd1000, 27'sd1000, 27'sd0, 27'sd999};
    run_stim(1);
    flush();

    // T6: long ramp forces end of rise
    threshold = 26'd1000;
    stim.delete();
    for (int k = 0; k < 300; k++) stim.push_back(27'(1001 + 7 * k));
    run_stim(2);
    flush();

    // randomized scenarios
    for (int s = 0; s < 4; s++) begin
      threshold = 26'($urandom_range(100, 5000));
      stim.delete();
      burst = 0;
      lvl = 0;
      for (int k = 0; k < 500; k++) begin
        if (burst > 0) begin
          lvl += $urandom_range(0, 300);
          burst--;
          v = 27'(lvl);
        end else if ($urandom_range(0, 39) == 0) begin
          burst = $urandom_range(1, 20);
          lvl = int'(threshold) + $urandom_range(0, 200);
          v = 27'(lvl);
        end else if ($urandom_range(0, 199) == 0) begin
          v = 27'sh4000000;
        end else begin
          v = 27'($urandom_range(0, int'(threshold)));
        end
        if ($urandom_range(0, 1) == 1 && v != 27'sh4000000) v = -v;
        stim.push_back(v);
      end
      run_stim(2);
      flush();
    end

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
